// File: rtl/fc_pkg.sv
// Shared FC-layer package: default geometry and the result-reader FSM encoding.
// Also imported by the FC layer modules.
package fc_pkg;

    localparam int FC_NUM_CLASSES = 2;
    localparam int FC_LOGIT_W     = 8;
    localparam int FC_ADDR_W      =
        (FC_NUM_CLASSES > 1) ? $clog2(FC_NUM_CLASSES) : 1;

    typedef enum logic [1:0] {
        FC_IDLE = 2'd0,
        FC_SCAN = 2'd1,
        FC_HOLD = 2'd2
    } fc_state_e;

endpackage

// File: rtl/fc_result_reader_if.sv
// Logit write bus plus result valid/ready handshake of the result reader.
// result_score_o exists only when FC_RESULT_SCORE_EN is defined.
interface fc_result_reader_if
    import fc_pkg::*;
#(
    parameter int ADDR_W  = FC_ADDR_W,
    parameter int LOGIT_W = FC_LOGIT_W
) ();

    logic               fc_output_wren_i;
    logic [ADDR_W-1:0]  fc_output_addr_i;
    logic [LOGIT_W-1:0] fc_output_data_i;
    logic               fc_done_i;
    logic               result_valid_o;
    logic               result_ready_i;
    logic [ADDR_W-1:0]  result_class_o;
`ifdef FC_RESULT_SCORE_EN
    logic [LOGIT_W-1:0] result_score_o;

    modport master (
        output fc_output_wren_i, fc_output_addr_i, fc_output_data_i,
        output fc_done_i, result_ready_i,
        input  result_valid_o, result_class_o, result_score_o
    );

    modport slave (
        input  fc_output_wren_i, fc_output_addr_i, fc_output_data_i,
        input  fc_done_i, result_ready_i,
        output result_valid_o, result_class_o, result_score_o
    );
`else
    modport master (
        output fc_output_wren_i, fc_output_addr_i, fc_output_data_i,
        output fc_done_i, result_ready_i,
        input  result_valid_o, result_class_o
    );

    modport slave (
        input  fc_output_wren_i, fc_output_addr_i, fc_output_data_i,
        input  fc_done_i, result_ready_i,
        output result_valid_o, result_class_o
    );
`endif

endinterface

// File: rtl/fc_argmax_step.sv
// One signed compare-and-select step of the argmax scan.
// The candidate wins only when strictly greater, so ties keep the lower index.
module fc_argmax_step
    import fc_pkg::*;
#(
    parameter int LOGIT_W = FC_LOGIT_W,
    parameter int ADDR_W  = FC_ADDR_W
) (
    input  logic signed [LOGIT_W-1:0] cur_max_i,
    input  logic        [ADDR_W-1:0]  cur_idx_i,
    input  logic signed [LOGIT_W-1:0] cand_i,
    input  logic        [ADDR_W-1:0]  cand_idx_i,
    output logic signed [LOGIT_W-1:0] new_max_o,
    output logic        [ADDR_W-1:0]  new_idx_o
);

    logic take;

    assign take      = cand_i > cur_max_i;
    assign new_max_o = take ? cand_i : cur_max_i;
    assign new_idx_o = take ? cand_idx_i : cur_idx_i;

endmodule

// File: rtl/fc_result_reader.sv
// Buffers final-layer logits and reports their argmax over a valid/ready handshake.
// Define FC_RESULT_SCORE_EN to also output the winning logit.
module fc_result_reader
    import fc_pkg::*;
#(
    parameter int NUM_CLASSES = FC_NUM_CLASSES,
    parameter int LOGIT_W     = FC_LOGIT_W,
    parameter int ADDR_W      = FC_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    fc_result_reader_if.slave bus,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam int CNT_W = $clog2(NUM_CLASSES + 2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_NC   = CNT_W'(NUM_CLASSES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_CLASSES + 1);
    localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(NUM_CLASSES);

    fc_state_e state_q, state_d;

    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [LOGIT_W-1:0] buf_q [NUM_CLASSES];
    logic signed [LOGIT_W-1:0] buf_d [NUM_CLASSES];
    logic signed [LOGIT_W-1:0] rd_data_q, rd_data_d;
    logic signed [LOGIT_W-1:0] max_q, max_d;
    logic        [ADDR_W-1:0]  max_idx_q, max_idx_d;
    logic                      valid_q, valid_d;
    logic        [ADDR_W-1:0]  class_q, class_d;
    logic                      overrun_q, overrun_d;
`ifdef FC_RESULT_SCORE_EN
    logic        [LOGIT_W-1:0] score_q, score_d;
`endif

    logic        [CNT_W-1:0]   cnt_m1;
    logic        [ADDR_W-1:0]  rd_idx;
    logic        [ADDR_W-1:0]  cand_idx;
    logic signed [LOGIT_W-1:0] step_max;
    logic        [ADDR_W-1:0]  step_idx;

    // Index k is read at cnt=k and compared one cycle later at cnt=k+1.
    assign cnt_m1   = cnt_q - 1'b1;
    assign rd_idx   = cnt_q[ADDR_W-1:0];
    assign cand_idx = cnt_m1[ADDR_W-1:0];

    fc_argmax_step #(
        .LOGIT_W (LOGIT_W),
        .ADDR_W  (ADDR_W)
    ) u_step (
        .cur_max_i  (max_q),
        .cur_idx_i  (max_idx_q),
        .cand_i     (rd_data_q),
        .cand_idx_i (cand_idx),
        .new_max_o  (step_max),
        .new_idx_o  (step_idx)
    );

    always_comb begin
        buf_d = buf_q;
        if (bus.fc_output_wren_i &&
            ({1'b0, bus.fc_output_addr_i} < ADDR_LIM)) begin
            buf_d[bus.fc_output_addr_i] = bus.fc_output_data_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        valid_d   = valid_q;
        class_d   = class_q;
        overrun_d = overrun_q;
`ifdef FC_RESULT_SCORE_EN
        score_d   = score_q;
`endif
        unique case (state_q)
            FC_IDLE: begin
                if (bus.fc_done_i) begin
                    state_d = FC_SCAN;
                    cnt_d   = '0;
                end
            end
            FC_SCAN: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.fc_done_i) overrun_d = 1'b1;
                if (cnt_q < CNT_NC) rd_data_d = buf_q[rd_idx];
                if (cnt_q == CNT_ONE) begin
                    max_d     = rd_data_q;
                    max_idx_d = cand_idx;
                end else if (cnt_q != '0 && cnt_q <= CNT_NC) begin
                    max_d     = step_max;
                    max_idx_d = step_idx;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = FC_HOLD;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    class_d = max_idx_q;
`ifdef FC_RESULT_SCORE_EN
                    score_d = max_q;
`endif
                end
            end
            FC_HOLD: begin
                if (bus.fc_done_i) overrun_d = 1'b1;
                if (valid_q && bus.result_ready_i) begin
                    state_d = FC_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = FC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= FC_IDLE;
            cnt_q     <= '0;
            rd_data_q <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
            valid_q   <= 1'b0;
            class_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            valid_q   <= valid_d;
            class_q   <= class_d;
            overrun_q <= overrun_d;
            buf_q     <= buf_d;
        end
    end

`ifdef FC_RESULT_SCORE_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) score_q <= '0;
        else          score_q <= score_d;
    end

    assign bus.result_score_o = score_q;
`endif

    assign bus.result_valid_o = valid_q;
    assign bus.result_class_o = class_q;
    assign busy_o             = state_q != FC_IDLE;
    assign overrun_o          = overrun_q;

endmodule

// File: tb/tb_fc_result_reader.sv
// Directed plus random checks of fc_result_reader against an argmax model.
// Score checks are compiled only when FC_RESULT_SCORE_EN is defined.
module tb_fc_result_reader;
    import fc_pkg::*;

    localparam int NC = 2;
    localparam int LW = 8;
    localparam int AW = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic overrun;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic signed [LW-1:0] mdl [NC];

    fc_result_reader_if #(.ADDR_W(AW), .LOGIT_W(LW)) bus ();

    fc_result_reader #(
        .NUM_CLASSES (NC),
        .LOGIT_W     (LW),
        .ADDR_W      (AW)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .bus       (bus),
        .busy_o    (busy),
        .overrun_o (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [LW-1:0] d);
        bus.fc_output_wren_i = 1'b1;
        bus.fc_output_addr_i = a;
        bus.fc_output_data_i = d;
        mdl[a] = d;
        step();
        bus.fc_output_wren_i = 1'b0;
    endtask

    // Plain argmax: first index holding the largest signed value.
    function automatic int ref_class();
        int best = 0;
        for (int i = 1; i < NC; i++)
            if (mdl[i] > mdl[best]) best = i;
        return best;
    endfunction

    task automatic check_result(input string tag, input int ec,
                                input logic [LW-1:0] es);
        check({tag, ".valid"}, bus.result_valid_o, 1);
        check({tag, ".class"}, bus.result_class_o, ec);
`ifdef FC_RESULT_SCORE_EN
        check({tag, ".score"}, bus.result_score_o, es);
`else
        if (es === 'x) check({tag, ".score_x"}, 0, 1);
`endif
    endtask

    task automatic handshake(input string tag);
        bus.result_ready_i = 1'b1;
        step();
        bus.result_ready_i = 1'b0;
        check({tag, ".drop"}, bus.result_valid_o, 0);
        check({tag, ".idle"}, busy, 0);
    endtask

    task automatic run_scan(input string tag, input int hold);
        int ec;
        logic [LW-1:0] es;
        ec = ref_class();
        es = mdl[ec];
        bus.fc_done_i = 1'b1;
        step();
        bus.fc_done_i = 1'b0;
        check({tag, ".busy"}, busy, 1);
        repeat (NC + 1) step();
        check({tag, ".early"}, bus.result_valid_o, 0);
        step();
        check_result(tag, ec, es);
        for (int i = 0; i < hold; i++) begin
            step();
            check_result({tag, ".hold"}, ec, es);
        end
        handshake(tag);
    endtask

    initial begin
        bus.fc_output_wren_i = 1'b0;
        bus.fc_output_addr_i = '0;
        bus.fc_output_data_i = '0;
        bus.fc_done_i        = 1'b0;
        bus.result_ready_i   = 1'b0;
        for (int i = 0; i < NC; i++) mdl[i] = '0;
        #12;
        check("rst.valid", bus.result_valid_o, 0);
        check("rst.class", bus.result_class_o, 0);
        check("rst.busy", busy, 0);
        check("rst.overrun", overrun, 0);
`ifdef FC_RESULT_SCORE_EN
        check("rst.score", bus.result_score_o, 0);
`endif
        rst_n = 1'b1;
        step();

        wr(0, 8'h10); wr(1, 8'h20); run_scan("basic", 0);
        wr(0, 8'h7F); wr(1, 8'h80); run_scan("signed_a", 0);
        wr(0, 8'hF0); wr(1, 8'h05); run_scan("signed_b", 0);
        wr(0, 8'h33); wr(1, 8'h33); run_scan("tie", 0);
        wr(0, 8'h01); wr(1, 8'h42); run_scan("stall", 5);

        // Index 0 is rewritten after it has already been read.
        wr(0, 8'h50); wr(1, 8'h20);
        bus.fc_done_i = 1'b1;
        step();
        bus.fc_done_i = 1'b0;
        step();
        bus.fc_output_wren_i = 1'b1;
        bus.fc_output_addr_i = 1'b0;
        bus.fc_output_data_i = 8'h01;
        step();
        bus.fc_output_wren_i = 1'b0;
        mdl[0] = 8'h01;
        step();
        check("midscan.early", bus.result_valid_o, 0);
        step();
        check_result("midscan", 0, 8'h50);
        handshake("midscan");

        // Write coincident with done, then a second done during the scan.
        wr(0, 8'h40);
        bus.fc_output_wren_i = 1'b1;
        bus.fc_output_addr_i = 1'b1;
        bus.fc_output_data_i = 8'h60;
        mdl[1] = 8'h60;
        bus.fc_done_i = 1'b1;
        step();
        bus.fc_output_wren_i = 1'b0;
        step();
        bus.fc_done_i = 1'b0;
        check("ovr.flag", overrun, 1);
        repeat (NC) step();
        check("ovr.early", bus.result_valid_o, 0);
        step();
        check_result("ovr", 1, 8'h60);
        handshake("ovr");
        for (int i = 0; i < 8; i++) begin
            step();
            check("ovr.no_second", bus.result_valid_o, 0);
        end
        check("ovr.sticky", overrun, 1);

        // Reset in the middle of a scan.
        wr(0, 8'h11); wr(1, 8'h22);
        bus.fc_done_i = 1'b1;
        step();
        bus.fc_done_i = 1'b0;
        step();
        check("abort.busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort.valid", bus.result_valid_o, 0);
        check("abort.class", bus.result_class_o, 0);
        check("abort.busy", busy, 0);
        check("abort.overrun", overrun, 0);
`ifdef FC_RESULT_SCORE_EN
        check("abort.score", bus.result_score_o, 0);
`endif
        for (int i = 0; i < NC; i++) mdl[i] = '0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("abort.no_valid", bus.result_valid_o | busy, 0);
        end
        run_scan("abort.fresh", 0);

        for (int n = 0; n < 20; n++) begin
            wr(0, LW'($urandom));
            wr(1, LW'($urandom));
            if (n % 4 == 0) wr(1, mdl[0]);
            run_scan("rand", $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_result_reader.md
FC_RESULT_READER -- requirements
Module: fc_result_reader

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 2; number of logits in the result buffer.
REQ-002 SHALL have parameter LOGIT_W, default 8; logit width, signed two's complement.
REQ-003 SHALL have parameter ADDR_W, default 1; buffer index width, equal to max(1, clog2(NUM_CLASSES)).
REQ-004 SHALL have port clk_i  input  1  clock, rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port fc_output_wren_i  input  1  logit write strobe from the final FC layer.
REQ-007 SHALL have port fc_output_addr_i  input  ADDR_W  logit write index.
REQ-008 SHALL have port fc_output_data_i  input  LOGIT_W  logit write data.
REQ-009 SHALL have port fc_done_i  input  1  single-cycle pulse: all logits written.
REQ-010 SHALL have port result_valid_o  output  1  classification result available.
REQ-011 SHALL have port result_ready_i  input  1  downstream accepts the result.
REQ-012 SHALL have port result_class_o  output  ADDR_W  argmax index.
REQ-013 SHALL have port result_score_o  output  LOGIT_W  winning logit (only with FC_RESULT_SCORE_EN).
REQ-014 SHALL have port busy_o  output  1  high whenever the FSM is not IDLE.
REQ-015 SHALL have port overrun_o  output  1  sticky flag: fc_done_i arrived while busy.

Function
REQ-016 SHALL store logits in an internal NUM_CLASSES x LOGIT_W buffer written on every cycle with fc_output_wren_i=1, in any state; an out-of-range address is dropped.
REQ-017 SHALL read the buffer through a registered read port, so data appears one cycle after the read index is presented.
REQ-018 SHALL implement FSM states IDLE, SCAN, HOLD: IDLE->SCAN on fc_done_i; SCAN->HOLD after the last logit is compared; HOLD->IDLE when result_valid_o and result_ready_i are both high.
REQ-019 SHALL, in SCAN, issue read indices 0..NUM_CLASSES-1 on consecutive cycles and compare each returned logit as signed against the running maximum.
REQ-020 SHALL load logit 0 unconditionally as the initial maximum.
REQ-021 SHALL replace the maximum only on strictly greater, so ties resolve to the lowest index.
REQ-022 SHALL raise result_valid_o at clock edge T+NUM_CLASSES+2 when fc_done_i is sampled at edge T.
REQ-023 SHALL hold result_valid_o, result_class_o and result_score_o stable in HOLD until the handshake completes.
REQ-024 SHALL drop result_valid_o on the edge that completes the handshake and return to IDLE; a new fc_done_i is accepted from the following cycle.
REQ-025 SHALL make a write coincident with the fc_done_i pulse visible to the scan.
REQ-026 SHALL ignore fc_done_i in SCAN or HOLD and set overrun_o; overrun_o clears only on reset.
REQ-027 SHALL NOT disturb a scan already in flight when writes occur during SCAN; the logit at each index is whatever the buffer held when that index was read.

Reset
REQ-028 SHALL, on reset, enter IDLE and drive result_valid_o=0, result_class_o=0, result_score_o=0, busy_o=0, overrun_o=0, with the buffer cleared to 0.
REQ-029 SHALL, on reset asserted during SCAN or HOLD, abort immediately with no result delivered; after release the block waits for a fresh fc_done_i.

Configuration
REQ-030 SHALL, with macro FC_RESULT_SCORE_EN defined, include port result_score_o and its register.
REQ-031 SHALL, without FC_RESULT_SCORE_EN, omit result_score_o and its register entirely; the comparator still tracks the running max internally, and result_class_o timing is unchanged.

Structure
REQ-032 SHALL take NUM_CLASSES, LOGIT_W, ADDR_W defaults and the FSM state encoding from shared package fc_pkg, also used by the FC layer modules.
REQ-033 SHALL place the signed compare-and-select step in sub-module fc_argmax_step (inputs: current max/index, candidate/index; outputs: new max/index).

Verification
REQ-034 SHALL cover: write {0x10, 0x20}, pulse done at T -> valid at T+4, class=1, score=0x20.
REQ-035 SHALL cover: write {0x7F, 0x80} -> class=0, score=0x7F (signed compare); write {0xF0, 0x05} -> class=1, score=0x05.
REQ-036 SHALL cover: write {0x33, 0x33} -> class=0 (tie goes to the lower index).
REQ-037 SHALL cover: hold ready low 5 cycles in HOLD -> valid, class, score stable; ready high -> valid low next edge, busy_o low.
REQ-038 SHALL cover: second done pulse in SCAN -> overrun_o=1 and stays 1, first result unaffected, no second result; write index 1 in the same cycle as done -> the new value is used.
REQ-039 SHALL cover: reset asserted in SCAN -> all outputs 0 immediately, no valid after release until a new done.
